program_loader: RTL

Writes a program image into the instruction memory unit from a byte stream and holds the processor in clear until the image is complete. The processor only reads instruction memory; this block is the writer side of that memory port. It sits between an external byte source (UART receiver or testbench) and the instruction memory write port. Its `cpu_hold` output drives the processor core's `clr`.

---
 rtl/loader_pkg.sv | 28 ++
 rtl/word_packer.sv | 37 +++
 rtl/program_loader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// PROGRAM_LOADER_CHECKSUM_EN adds the CHK state to the loader FSM.
package loader_pkg;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_DATA   = 3'd3,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ST_CHK    = 3'd4,
`endif
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_t;

  // An image must hold at least one word and fit in the memory limit.
  function automatic logic hdr_in_range(input logic [HDR_BYTES*8-1:0] n,
                                        input int max_words);
    logic [31:0] n_ext;
    n_ext = {{(32-HDR_BYTES*8){1'b0}}, n};
    return (n != {(HDR_BYTES*8){1'b0}}) && (n_ext <= 32'(max_words));
  endfunction

endpackage

// File: rtl/word_packer.sv
// Assembles four stream bytes, most significant first, into one 32-bit word.
// The assembled word and word_ready are presented in the cycle of the 4th byte.
module word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        load,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [31:0] shift_r;
  logic [1:0]  cnt_r;

  // Combinational view of the word including the byte arriving now.
  always_comb begin
    word       = {shift_r[23:0], byte_in};
    word_ready = shift_en && (cnt_r == LAST_IDX);
  end

  // Shift register and byte counter; a new load discards any partial word.
  always_ff @(posedge clk) begin
    if (clr || load) begin
      shift_r <= 32'd0;
      cnt_r   <= 2'd0;
    end else if (shift_en) begin
      shift_r <= word;
      cnt_r   <= cnt_r + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Writes a length-prefixed byte stream into instruction memory and holds the CPU in clear
// until the image is complete. Define PROGRAM_LOADER_CHECKSUM_EN for a trailing XOR checksum.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  loader_state_t            state_r;
  logic [7:0]               n_hi_r;
  logic [ADDR_W:0]          n_r;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]               xor_r;
`endif

  logic                     xfer_s;
  logic                     load_s;
  logic                     shift_en_s;
  logic                     last_word_s;
  logic [HDR_BYTES*8-1:0]   n_s;
  logic [31:0]              word_s;
  logic                     word_ready_s;

  // Handshake decode and header/word-count comparisons.
  always_comb begin
    xfer_s      = byte_valid && byte_ready;
    n_s         = {n_hi_r, byte_data};
    load_s      = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) ||
                            (state_r == ST_ERR));
    shift_en_s  = xfer_s && (state_r == ST_DATA);
    last_word_s = ((word_count + CNT_ONE) == n_r);
  end

  word_packer u_packer (
    .clk        (clk),
    .clr        (clr),
    .load       (load_s),
    .shift_en   (shift_en_s),
    .byte_in    (byte_data),
    .word       (word_s),
    .word_ready (word_ready_s)
  );

  // Loader FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r    <= ST_IDLE;
      n_hi_r     <= 8'd0;
      n_r        <= {(ADDR_W+1){1'b0}};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      xor_r      <= 8'd0;
`endif
      byte_ready <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= {ADDR_W{1'b0}};
      mem_data   <= 32'd0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= {(ADDR_W+1){1'b0}};
    end else begin
      mem_wen <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state_r    <= ST_HDR_HI;
            byte_ready <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= {(ADDR_W+1){1'b0}};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xor_r      <= 8'd0;
`endif
          end else if (state_r == ST_DONE) begin
            // Release lands one cycle after the final write strobe.
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
        end
        ST_HDR_HI: begin
          if (xfer_s) begin
            n_hi_r  <= byte_data;
            state_r <= ST_HDR_LO;
          end
        end
        ST_HDR_LO: begin
          if (xfer_s) begin
            if (hdr_in_range(n_s, MAX_WORDS)) begin
              n_r     <= n_s[ADDR_W:0];
              state_r <= ST_DATA;
            end else begin
              state_r    <= ST_ERR;
              error      <= 1'b1;
              byte_ready <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (xfer_s) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xor_r <= xor_r ^ byte_data;
`endif
            if (word_ready_s) begin
              mem_wen    <= 1'b1;
              mem_addr   <= word_count[ADDR_W-1:0];
              mem_data   <= word_s;
              word_count <= word_count + CNT_ONE;
              if (last_word_s) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                state_r    <= ST_CHK;
`else
                state_r    <= ST_DONE;
                byte_ready <= 1'b0;
`endif
              end
            end
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (xfer_s) begin
            byte_ready <= 1'b0;
            if (byte_data == xor_r) begin
              state_r  <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state_r <= ST_ERR;
              error   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_r    <= ST_IDLE;
          byte_ready <= 1'b0;
          cpu_hold   <= 1'b1;
        end
      endcase
    end
  end

endmodule
